// File: rtl/bp_me_stream_arbiter_pkg.sv
// bp_me_stream_arbiter_pkg: types shared by the BedRock stream arbiter files
package bp_me_stream_arbiter_pkg;

    typedef enum logic {e_idle, e_lock} state_e;

endpackage

// File: rtl/bp_me_stream_arbiter_rr.sv
// bp_me_stream_arbiter_rr: round-robin pick of the lowest requester at or after the pointer
module bp_me_stream_arbiter_rr #(
    parameter int num_src_p     = 4,
    parameter int lg_num_src_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [num_src_p-1:0]     reqs_i,
    input  logic                     yumi_i,
    input  logic [lg_num_src_lp-1:0] yumi_id_i,
    output logic [lg_num_src_lp-1:0] grant_id_o
);

    logic [lg_num_src_lp-1:0] ptr_q;

    // Scan from the farthest offset back to the pointer so the nearest requester wins
    always_comb begin
        grant_id_o = ptr_q;
        for (int k = num_src_p - 1; k >= 0; k--) begin
            if (reqs_i[(int'(ptr_q) + k) % num_src_p])
                grant_id_o = lg_num_src_lp'((int'(ptr_q) + k) % num_src_p);
        end
    end

    // Move the pointer past the source whose message just finished
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            ptr_q <= '0;
        else if (yumi_i)
            ptr_q <= (int'(yumi_id_i) == num_src_p - 1) ? '0 : yumi_id_i + lg_num_src_lp'(1);
    end

endmodule

// File: rtl/bp_me_stream_arbiter.sv
// bp_me_stream_arbiter: message-granular round-robin share of one BedRock Burst sink
module bp_me_stream_arbiter
    import bp_me_stream_arbiter_pkg::*;
#(
    parameter int num_src_p       = 4,
    parameter int pr_hdr_width_p  = 8,
    parameter int pr_data_width_p = 8,
    parameter int cord_width_p    = 4,
    parameter int cid_width_p     = 1,
    parameter int lg_num_src_lp   = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_src_p*pr_hdr_width_p-1:0]  pr_hdr_i,
    input  logic [num_src_p*pr_data_width_p-1:0] pr_data_i,
    input  logic [num_src_p-1:0]                 pr_last_i,
    input  logic [num_src_p*cord_width_p-1:0]    dst_cord_i,
    input  logic [num_src_p*cid_width_p-1:0]     dst_cid_i,
    input  logic [num_src_p-1:0]                 pr_v_i,
    output logic [num_src_p-1:0]                 pr_ready_and_o,
    output logic [pr_hdr_width_p-1:0]            pr_hdr_o,
    output logic [pr_data_width_p-1:0]           pr_data_o,
    output logic                                 pr_last_o,
    output logic [cord_width_p-1:0]              dst_cord_o,
    output logic [cid_width_p-1:0]               dst_cid_o,
    output logic                                 pr_v_o,
    input  logic                                 pr_ready_and_i,
    output logic [lg_num_src_lp-1:0]             grant_id_o,
    output logic                                 grant_v_o
);

    state_e                   state_q;
    logic [lg_num_src_lp-1:0] grant_q, pick_id, sel_id;
    logic                     accept, last_accept;

    assign accept      = pr_v_o & pr_ready_and_i;
    assign last_accept = accept & pr_last_o;

    bp_me_stream_arbiter_rr #(
        .num_src_p    (num_src_p),
        .lg_num_src_lp(lg_num_src_lp)
    ) rr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs_i    (pr_v_i),
        .yumi_i    (last_accept),
        .yumi_id_i (sel_id),
        .grant_id_o(pick_id)
    );

    // Steer the locked source (or the fresh pick) straight through; reset blanks the handshake
    always_comb begin
        sel_id         = (state_q == e_lock) ? grant_q : pick_id;
        grant_v_o      = reset_n_i & ((state_q == e_lock) | (|pr_v_i));
        pr_v_o         = reset_n_i & ((state_q == e_lock) ? pr_v_i[grant_q] : (|pr_v_i));
        grant_id_o     = reset_n_i ? sel_id : '0;
        pr_hdr_o       = '0;
        pr_data_o      = '0;
        pr_last_o      = 1'b0;
        dst_cord_o     = '0;
        dst_cid_o      = '0;
        pr_ready_and_o = '0;
        for (int i = 0; i < num_src_p; i++) begin
            if (int'(sel_id) == i) begin
                pr_hdr_o          = pr_hdr_i[i*pr_hdr_width_p +: pr_hdr_width_p];
                pr_data_o         = pr_data_i[i*pr_data_width_p +: pr_data_width_p];
                pr_last_o         = pr_last_i[i];
                dst_cord_o        = dst_cord_i[i*cord_width_p +: cord_width_p];
                dst_cid_o         = dst_cid_i[i*cid_width_p +: cid_width_p];
                pr_ready_and_o[i] = grant_v_o & pr_ready_and_i;
            end
        end
    end

    // Lock onto a source after its first non-last beat; release on its last beat
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            grant_q <= '0;
        end else if (state_q == e_idle && accept && !pr_last_o) begin
            state_q <= e_lock;
            grant_q <= sel_id;
        end else if (state_q == e_lock && last_accept) begin
            state_q <= e_idle;
        end
    end

`ifndef SYNTHESIS
    logic                     hold_q;
    logic [lg_num_src_lp-1:0] hold_id_q;

    // An idle winner that was not accepted must keep its valid up, or the grant would shift
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q    <= 1'b0;
            hold_id_q <= '0;
        end else begin
            assert (!hold_q || pr_v_i[hold_id_q])
                else $error("bp_me_stream_arbiter: idle winner %0d dropped valid before accept", hold_id_q);
            hold_q    <= (state_q == e_idle) && grant_v_o && !pr_ready_and_i;
            hold_id_q <= sel_id;
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// tb_bp_me_stream_arbiter: table-driven directed checks of the stream arbiter
module tb_bp_me_stream_arbiter;

    localparam int N = 4, HW = 8, DW = 8, CW = 4, IW = 1;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] last;
        logic       rdy;
        logic       pv;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] prdy;
        logic       plast;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*HW-1:0] hdr_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    last_i = '0;
    logic [N*CW-1:0] cord_i;
    logic [N*IW-1:0] cid_i;
    logic [N-1:0]    v_i = '0;
    logic            rdy_i = 1'b1;
    logic [N-1:0]    pr_ready_and_o;
    logic [HW-1:0]   pr_hdr_o;
    logic [DW-1:0]   pr_data_o;
    logic            pr_last_o;
    logic [CW-1:0]   dst_cord_o;
    logic [IW-1:0]   dst_cid_o;
    logic            pr_v_o;
    logic [1:0]      grant_id_o;
    logic            grant_v_o;

    int   vecs = 0;
    int   errs = 0;
    vec_t q[$];

    always #5 clk = ~clk;

    bp_me_stream_arbiter #(
        .num_src_p(N), .pr_hdr_width_p(HW), .pr_data_width_p(DW),
        .cord_width_p(CW), .cid_width_p(IW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .pr_hdr_i(hdr_i), .pr_data_i(data_i), .pr_last_i(last_i),
        .dst_cord_i(cord_i), .dst_cid_i(cid_i), .pr_v_i(v_i),
        .pr_ready_and_o(pr_ready_and_o), .pr_hdr_o(pr_hdr_o), .pr_data_o(pr_data_o),
        .pr_last_o(pr_last_o), .dst_cord_o(dst_cord_o), .dst_cid_o(dst_cid_o),
        .pr_v_o(pr_v_o), .pr_ready_and_i(rdy_i),
        .grant_id_o(grant_id_o), .grant_v_o(grant_v_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic [3:0] v, input logic [3:0] last, input logic rdy,
                       input logic pv, input logic gv, input logic [1:0] gid,
                       input logic [3:0] prdy, input logic plast);
        q.push_back({v, last, rdy, pv, gv, gid, prdy, plast});
    endtask

    initial begin
        logic [23:0] af, ef;
        logic [1:0]  g;
        for (int s = 0; s < N; s++) begin
            hdr_i[s*HW +: HW]  = 8'hA0 + 8'(s);
            data_i[s*DW +: DW] = 8'hD0 + 8'(s);
            cord_i[s*CW +: CW] = 4'(s + 1);
            cid_i[s]           = 1'(s % 2);
        end
        // header-only messages from 0 and 2 alternate
        row(4'b0101, 4'b0101, 1, 1, 1, 2'd0, 4'b0001, 1);
        row(4'b0101, 4'b0101, 1, 1, 1, 2'd2, 4'b0100, 1);
        row(4'b0101, 4'b0101, 1, 1, 1, 2'd0, 4'b0001, 1);
        row(4'b0101, 4'b0101, 1, 1, 1, 2'd2, 4'b0100, 1);
        row(4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 0);
        // source 1 holds four beats while source 0 waits
        row(4'b0011, 4'b0001, 1, 1, 1, 2'd0, 4'b0001, 1);
        row(4'b0011, 4'b0001, 1, 1, 1, 2'd1, 4'b0010, 0);
        row(4'b0011, 4'b0001, 1, 1, 1, 2'd1, 4'b0010, 0);
        row(4'b0011, 4'b0001, 1, 1, 1, 2'd1, 4'b0010, 0);
        row(4'b0011, 4'b0011, 1, 1, 1, 2'd1, 4'b0010, 1);
        row(4'b0001, 4'b0001, 1, 1, 1, 2'd0, 4'b0001, 1);
        // sink stalls five cycles inside source 3's message
        row(4'b1001, 4'b0001, 1, 1, 1, 2'd3, 4'b1000, 0);
        row(4'b1001, 4'b0001, 1, 1, 1, 2'd3, 4'b1000, 0);
        for (int k = 0; k < 5; k++) row(4'b1001, 4'b0001, 0, 1, 1, 2'd3, 4'b0000, 0);
        row(4'b1001, 4'b1001, 1, 1, 1, 2'd3, 4'b1000, 1);
        row(4'b0001, 4'b0001, 1, 1, 1, 2'd0, 4'b0001, 1);
        // source 2 bubbles for two cycles while locked
        row(4'b0101, 4'b0001, 1, 1, 1, 2'd2, 4'b0100, 0);
        row(4'b0001, 4'b0001, 1, 0, 1, 2'd2, 4'b0100, 0);
        row(4'b0001, 4'b0001, 1, 0, 1, 2'd2, 4'b0100, 0);
        row(4'b0101, 4'b0101, 1, 1, 1, 2'd2, 4'b0100, 1);
        row(4'b0001, 4'b0001, 1, 1, 1, 2'd0, 4'b0001, 1);
        // realign pointer to 0, then all four stream 2-beat messages
        row(4'b1000, 4'b1000, 1, 1, 1, 2'd3, 4'b1000, 1);
        for (int k = 0; k < 5; k++) begin
            row(4'b1111, 4'b0000, 1, 1, 1, 2'(k), 4'b0001 << (k % 4), 0);
            row(4'b1111, 4'b0001 << (k % 4), 1, 1, 1, 2'(k), 4'b0001 << (k % 4), 1);
        end
        row(4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 0);

        v_i = 4'b1111;
        #3;
        chk("reset_pv", 64'(pr_v_o), 64'd0);
        chk("reset_ready", 64'(pr_ready_and_o), 64'd0);
        chk("reset_gv", 64'(grant_v_o), 64'd0);
        chk("reset_gid", 64'(grant_id_o), 64'd0);
        v_i = '0;
        #9 reset_n = 1'b1;

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            v_i = q[i].v;
            last_i = q[i].last;
            rdy_i = q[i].rdy;
            @(negedge clk);
            g  = q[i].gid;
            af = {grant_id_o, pr_last_o, pr_hdr_o, pr_data_o, dst_cord_o, dst_cid_o};
            ef = {g, q[i].plast, 8'hA0 + 8'(g), 8'hD0 + 8'(g), 4'(g) + 4'd1, g[0]};
            chk($sformatf("row%0d", i),
                64'({pr_v_o, grant_v_o, pr_ready_and_o, q[i].gv ? af : 24'd0}),
                64'({q[i].pv, q[i].gv, q[i].prdy, q[i].gv ? ef : 24'd0}));
        end

        // async reset while source 2 is locked
        @(posedge clk);
        #1;
        v_i = 4'b0100;
        last_i = '0;
        rdy_i = 1'b1;
        @(posedge clk);
        #1;
        v_i = 4'b0110;
        #1;
        chk("lock_before_reset", 64'({pr_v_o, grant_id_o, pr_ready_and_o}), 64'({1'b1, 2'd2, 4'b0100}));
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_out", 64'({pr_v_o, grant_v_o, grant_id_o, pr_ready_and_o}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        last_i = 4'b0110;
        #1;
        chk("post_reset_grant", 64'({pr_v_o, grant_v_o, grant_id_o, pr_ready_and_o}),
            64'({1'b1, 1'b1, 2'd1, 4'b0010}));
        @(posedge clk);
        #1;
        chk("post_reset_next", 64'({grant_id_o, pr_ready_and_o}), 64'({2'd2, 4'b0100}));
        @(posedge clk);
        #1;
        v_i = '0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
